apb_uart_regfile: RTL

Parametrised APB3 slave register file for the UART core. It replaces the fixed 8-bit, 4-entry, no-wait-state APB interface. Adds configurable data width, programmable wait states, PSLVERR, a status register, TX/RX strobes and a maskable interrupt. Sits between the APB bus and the UART baud generator, TX FIFO and RX buffer.

---
 rtl/apb_uart_regfile.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/apb_uart_regfile.sv
// apb_uart_regfile: APB3 slave register file for the UART core (baud, ctrl, tx/rx data, status, irq enable).
// Latency: setup cycle plus WAIT_STATES+1 access cycles per transfer; tx_wr, rx_rd and irq follow their cause by one cycle.
// Backpressure: pready is held low for WAIT_STATES access cycles; TXDATA writes while tx_rdy=0 are refused with pslverr.
module apb_uart_regfile #(
  parameter int                 DATA_W      = 8,
  parameter int                 ADDR_W      = 3,
  parameter int                 WAIT_STATES = 0,
  parameter logic [DATA_W-1:0]  BAUD_RST    = '0
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] baud_val,
  output logic [DATA_W-1:0] ctrl,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_rdy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_rdy,
  output logic              rx_rd,
  input  logic              rx_ovf,
  output logic              irq
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0]        WS        = 4'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] IDX_BAUD  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] IDX_CTRL  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_TX    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] IDX_RX    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] IDX_STAT  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] IDX_IRQEN = ADDR_W'(5);

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] baud_q;
  logic [DATA_W-1:0] ctrl_q;
  logic [DATA_W-1:0] tx_q;
  logic [2:0]        irq_en;
  logic              ovf;
  logic [2:0]        status;
  logic              done;
  logic              err;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_mux;

  assign status   = {ovf, rx_rdy, tx_rdy};
  // A transfer completes on the access cycle where the wait count is exhausted and the master still holds the access phase.
  assign done     = (state == ACCESS) && psel && penable && (cnt == WS);
  assign wr_ok    = done && pwrite && !err;

  assign pready   = done;
  assign pslverr  = done && err;
  assign prdata   = (done && !pwrite && !err) ? rd_mux : '0;
  assign baud_val = baud_q;
  assign ctrl     = ctrl_q;
  assign tx_data  = tx_q;

  // Error decode: unmapped index, write to a read-only register, or TXDATA write the FIFO cannot take.
  always_comb begin
    err = 1'b0;
    if (paddr > IDX_IRQEN)
      err = 1'b1;
    else if (pwrite && ((paddr == IDX_RX) || (paddr == IDX_STAT)))
      err = 1'b1;
    else if (pwrite && (paddr == IDX_TX) && !tx_rdy)
      err = 1'b1;
  end

  // Read data mux; STATUS shows ovf before any read-to-clear takes effect.
  always_comb begin
    rd_mux = '0;
    case (paddr)
      IDX_BAUD:  rd_mux = baud_q;
      IDX_CTRL:  rd_mux = ctrl_q;
      IDX_TX:    rd_mux = tx_q;
      IDX_RX:    rd_mux = rx_data;
      IDX_STAT:  rd_mux = DATA_W'(status);
      IDX_IRQEN: rd_mux = DATA_W'(irq_en);
      default:   rd_mux = '0;
    endcase
  end

  // Transfer FSM: a setup cycle opens ACCESS; completion or a dropped psel/penable closes it.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state <= ACCESS;
            cnt   <= '0;
          end
        end
        ACCESS: begin
          if (!psel || !penable || done)
            state <= IDLE;
          else if (cnt < WS)
            cnt <= cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register commit on the edge that ends a completing, error-free write.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      baud_q <= BAUD_RST;
      ctrl_q <= '0;
      tx_q   <= '0;
      irq_en <= '0;
    end else if (wr_ok) begin
      case (paddr)
        IDX_BAUD:  baud_q <= pwdata;
        IDX_CTRL:  ctrl_q <= pwdata;
        IDX_TX:    tx_q   <= pwdata;
        IDX_IRQEN: irq_en <= pwdata[2:0];
        default:   ;
      endcase
    end
  end

  // Sticky overrun flag: a new overrun pulse beats a coincident STATUS read-to-clear.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)
      ovf <= 1'b0;
    else if (rx_ovf)
      ovf <= 1'b1;
    else if (done && !pwrite && (paddr == IDX_STAT))
      ovf <= 1'b0;
  end

  // One-cycle strobes towards the TX FIFO and RX buffer, and the registered interrupt level.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_wr <= 1'b0;
      rx_rd <= 1'b0;
      irq   <= 1'b0;
    end else begin
      tx_wr <= wr_ok && (paddr == IDX_TX);
      rx_rd <= done && !pwrite && (paddr == IDX_RX) && rx_rdy;
      irq   <= |(status & irq_en);
    end
  end

endmodule
